// File: rtl/ice40_serdes_deser_if.sv
// ice40_serdes_deser_if
//
// Bundles the deserializer's stream-side and word-side signals.
//   in_bits   : captured bit group from the IO registers (IW bits)
//   in_ce     : in_bits is valid this cycle
//   slip      : single-cycle request to move the word boundary later by IW bits
//   slip_busy : a slip has been accepted and its first word is not yet out
//   out_data  : assembled word, held between strobes (OW bits)
//   out_stb   : one-cycle pulse whenever out_data is updated
//
// master drives the stream side, slave is the deserializer itself.
interface ice40_serdes_deser_if #(
    parameter int IW = 2,
    parameter int OW = 8
);
    logic [IW-1:0] in_bits;
    logic          in_ce;
    logic          slip;
    logic          slip_busy;
    logic [OW-1:0] out_data;
    logic          out_stb;

    modport master (
        output in_bits,
        output in_ce,
        output slip,
        input  slip_busy,
        input  out_data,
        input  out_stb
    );

    modport slave (
        input  in_bits,
        input  in_ce,
        input  slip,
        output slip_busy,
        output out_data,
        output out_stb
    );
endinterface

// File: rtl/ice40_serdes_deser.sv
// ice40_serdes_deser
//
// Fabric deserializer placed behind the IO capture flops. Collects IW-bit
// groups (1 bit SDR or 2 bits DDR) into OW-bit words, with a clock enable
// for divided-rate streams, selectable bit order and a bit-slip for word
// alignment that moves the boundary later by one group.
//
// Ports:
//   clk : rising-edge clock for all logic
//   rst : synchronous active-high reset
//   bus : ice40_serdes_deser_if slave modport (in_bits, in_ce, slip in;
//         slip_busy, out_data, out_stb out)
//
// Parameters:
//   IW        : group width, 1 or 2
//   OW        : word width, a multiple of IW, 2..32
//   MSB_FIRST : 0 puts the first-received group in the word LSBs,
//               1 puts it in the MSBs
module ice40_serdes_deser #(
    parameter int IW        = 2,
    parameter int OW        = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    ice40_serdes_deser_if.slave   bus
);

    localparam int N  = OW / IW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [OW-1:0] r_sr;
    logic [CW-1:0] r_cnt;
    logic          r_slipPend;
    logic          r_slipBusy;
    logic [OW-1:0] r_outData;
    logic          r_outStb;

    logic [OW-1:0] w_srNext;
    logic          w_slipAcc;
    logic          w_slipEff;
    logic          w_wordDone;

    // A slip raised while one is still outstanding is simply dropped.
    assign w_slipAcc  = bus.slip & ~r_slipBusy;
    // A slip (fresh or parked) only takes effect together with a valid group.
    assign w_slipEff  = bus.in_ce & (w_slipAcc | r_slipPend);
    assign w_wordDone = bus.in_ce & ~w_slipEff & (r_cnt == LAST);

    // Shift direction decides where the earliest group ends up; when the
    // word is a single group the new group simply replaces the register.
    generate
        if (OW == IW) begin : g_single
            assign w_srNext = bus.in_bits;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign w_srNext = {r_sr[OW-IW-1:0], bus.in_bits};
        end else begin : g_lsb
            assign w_srNext = {bus.in_bits, r_sr[OW-1:IW]};
        end
    endgenerate

    // Datapath and group counter. A slipped group is still shifted in but
    // the counter does not advance, so the word takes one extra group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_slipPend <= 1'b0;
            r_outData  <= '0;
            r_outStb   <= 1'b0;
        end else begin
            r_outStb <= 1'b0;
            if (bus.in_ce) begin
                r_sr <= w_srNext;
                if (w_slipEff) begin
                    r_slipPend <= 1'b0;
                end else if (r_cnt == LAST) begin
                    r_outData <= w_srNext;
                    r_outStb  <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_slipAcc) begin
                r_slipPend <= 1'b1;
            end
        end
    end

    // Busy flag covers the whole realignment: set on acceptance, cleared as
    // the first word after the slip is strobed. Acceptance wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slipBusy <= 1'b0;
        end else if (w_slipAcc) begin
            r_slipBusy <= 1'b1;
        end else if (w_wordDone) begin
            r_slipBusy <= 1'b0;
        end
    end

    assign bus.slip_busy = r_slipBusy;
    assign bus.out_data  = r_outData;
    assign bus.out_stb   = r_outStb;

endmodule

// File: tb/tb_ice40_serdes_deser.sv
// tb_ice40_serdes_deser
//
// Directed bench for ice40_serdes_deser with IW=2, OW=8. Two instances share
// the same stimulus: one LSB-first, one MSB-first. Each scenario task drives
// groups and compares outputs against hand-computed words.
module tb_ice40_serdes_deser;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [1:0] pat [4];

    ice40_serdes_deser_if #(.IW(2), .OW(8)) bus0 ();
    ice40_serdes_deser_if #(.IW(2), .OW(8)) bus1 ();

    assign bus1.in_bits = bus0.in_bits;
    assign bus1.in_ce   = bus0.in_ce;
    assign bus1.slip    = bus0.slip;

    ice40_serdes_deser #(.IW(2), .OW(8), .MSB_FIRST(0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ice40_serdes_deser #(.IW(2), .OW(8), .MSB_FIRST(1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle of inputs, let the edge take them, then settle so
    // outputs are sampled well away from the active edge.
    task automatic applyStimulus(input logic [1:0] bits, input logic ce, input logic sl);
        bus0.in_bits = bits;
        bus0.in_ce   = ce;
        bus0.slip    = sl;
        @(posedge clk);
        #1;
        bus0.in_ce = 1'b0;
        bus0.slip  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Outputs must all be zero straight out of reset.
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(2'b11, 1'b1, 1'b1);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checks++;
        if (bus0.out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h expected 00", bus0.out_data);
        end
        checks++;
        if (bus0.out_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stb got %b expected 0", bus0.out_stb);
        end
        checks++;
        if (bus0.slip_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy got %b expected 0", bus0.slip_busy);
        end
        checks++;
        if (bus1.out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data_msb got %h expected 00", bus1.out_data);
        end
        rst = 1'b0;
    endtask

    // Continuous in_ce: a word every 4 groups, both bit orders.
    task automatic test_continuous();
        logic expStb;
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(pat[i % 4], 1'b1, 1'b0);
            expStb = ((i % 4) == 3);
            checks++;
            if (bus0.out_stb !== expStb) begin
                errors++;
                $display("[TB] FAIL cont_stb[%0d] got %b expected %b", i, bus0.out_stb, expStb);
            end
            if (expStb) begin
                checks++;
                if (bus0.out_data !== 8'h39) begin
                    errors++;
                    $display("[TB] FAIL cont_lsb[%0d] got %h expected 39", i, bus0.out_data);
                end
                checks++;
                if (bus1.out_data !== 8'h6C) begin
                    errors++;
                    $display("[TB] FAIL cont_msb[%0d] got %h expected 6c", i, bus1.out_data);
                end
            end
        end
    endtask

    // in_ce pattern 1,0,0: idle cycles must not count groups or move data.
    task automatic test_gapped();
        logic       expStb;
        logic [7:0] expData;
        doReset();
        expData = 8'h00;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pat[i % 4], 1'b1, 1'b0);
            expStb = ((i % 4) == 3);
            if (expStb) expData = 8'h39;
            checks++;
            if (bus0.out_stb !== expStb || bus0.out_data !== expData) begin
                errors++;
                $display("[TB] FAIL gap_valid[%0d] got stb=%b data=%h expected stb=%b data=%h",
                         i, bus0.out_stb, bus0.out_data, expStb, expData);
            end
            for (int j = 0; j < 2; j++) begin
                applyStimulus(~pat[i % 4], 1'b0, 1'b0);
                checks++;
                if (bus0.out_stb !== 1'b0 || bus0.out_data !== expData) begin
                    errors++;
                    $display("[TB] FAIL gap_idle[%0d.%0d] got stb=%b data=%h expected stb=0 data=%h",
                             i, j, bus0.out_stb, bus0.out_data, expData);
                end
            end
        end
    endtask

    // Slip with a group, a second slip while busy, then a slip parked on an
    // idle cycle and applied to the next valid group.
    task automatic test_slip();
        logic expStb;
        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(pat[i % 4], 1'b1, (i == 1) || (i == 2));
            expStb = (i == 4) || (i == 8);
            checks++;
            if (bus0.out_stb !== expStb) begin
                errors++;
                $display("[TB] FAIL slip_stb[%0d] got %b expected %b", i, bus0.out_stb, expStb);
            end
            if (expStb) begin
                checks++;
                if (bus0.out_data !== 8'h4E) begin
                    errors++;
                    $display("[TB] FAIL slip_data[%0d] got %h expected 4e", i, bus0.out_data);
                end
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus0.slip_busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL slip_busy_hi[%0d] got %b expected 1", i, bus0.slip_busy);
                end
            end
            if (i >= 5) begin
                checks++;
                if (bus0.slip_busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL slip_busy_lo[%0d] got %b expected 0", i, bus0.slip_busy);
                end
            end
        end

        applyStimulus(2'b00, 1'b0, 1'b1);
        checks++;
        if (bus0.slip_busy !== 1'b1 || bus0.out_stb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pend_accept got busy=%b stb=%b expected busy=1 stb=0",
                     bus0.slip_busy, bus0.out_stb);
        end
        for (int i = 9; i < 14; i++) begin
            applyStimulus(pat[i % 4], 1'b1, 1'b0);
            expStb = (i == 13);
            checks++;
            if (bus0.out_stb !== expStb) begin
                errors++;
                $display("[TB] FAIL pend_stb[%0d] got %b expected %b", i, bus0.out_stb, expStb);
            end
            if (expStb) begin
                checks++;
                if (bus0.out_data !== 8'h93) begin
                    errors++;
                    $display("[TB] FAIL pend_data got %h expected 93", bus0.out_data);
                end
            end
        end
        applyStimulus(2'b00, 1'b0, 1'b0);
        checks++;
        if (bus0.slip_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pend_busy_clear got %b expected 0", bus0.slip_busy);
        end
    endtask

    // Reset in the middle of a word (with a slip outstanding) wipes state;
    // the next four groups form a clean word.
    task automatic test_reset_midword();
        logic expStb;
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(pat[i], 1'b1, 1'b0);
        applyStimulus(pat[0], 1'b1, 1'b1);
        applyStimulus(pat[1], 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(pat[2], 1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if (bus0.out_data !== 8'h00 || bus0.out_stb !== 1'b0 || bus0.slip_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs got data=%h stb=%b busy=%b expected all 0",
                     bus0.out_data, bus0.out_stb, bus0.slip_busy);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pat[i], 1'b1, 1'b0);
            expStb = (i == 3);
            checks++;
            if (bus0.out_stb !== expStb) begin
                errors++;
                $display("[TB] FAIL midrst_stb[%0d] got %b expected %b", i, bus0.out_stb, expStb);
            end
        end
        checks++;
        if (bus0.out_data !== 8'h39) begin
            errors++;
            $display("[TB] FAIL midrst_data got %h expected 39", bus0.out_data);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        pat[0] = 2'b01;
        pat[1] = 2'b10;
        pat[2] = 2'b11;
        pat[3] = 2'b00;
        rst          = 1'b1;
        bus0.in_bits = 2'b00;
        bus0.in_ce   = 1'b0;
        bus0.slip    = 1'b0;

        test_reset();
        test_continuous();
        test_gapped();
        test_slip();
        test_reset_midword();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
